normalize_round: RTL and testbench

//  Post-add normalizer/rounder for the FP32 add/sub datapath; the inverse stage of significand alignment.

---
 rtl/normalize_round.sv | 196 +++++++++++++++++++
 tb/tb_normalize_round.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/normalize_round.sv
// normalize_round: post-add normalizer and round-to-nearest-even stage for FP32 add/sub.
// Build option: define SUBNORMAL_EN for gradual underflow. Without it, tiny results
// flush to signed zero.
module normalize_round #(
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_in,
    input  logic [7:0]  exp_in,
    input  logic [27:0] sig_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    localparam int unsigned SIG_W = 28;
    localparam int unsigned EXP_W = 10;
    localparam int unsigned LZ_W  = 5;
    localparam int unsigned MAN_W = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

    state_e                  state_q;
    logic                    sign_q;
    logic [SIG_W-1:0]        sig_q;
    logic signed [EXP_W-1:0] exp_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [31:0]             result_q;
    logic                    overflow_q;
    logic                    underflow_q;
    logic                    inexact_q;

    logic [LZ_W-1:0]         lz_d;
    logic [LZ_W-1:0]         shamt_d;
    logic [SIG_W-1:0]        sig_shl_d;
    logic signed [EXP_W-1:0] exp_shl_d;
    logic [SIG_W-1:0]        sig_rsh_d;

    logic                    round_up_d;
    logic                    inx_raw_d;
    logic [MAN_W:0]          m_sum_d;
    logic [MAN_W-1:0]        mant_d;
    logic signed [EXP_W-1:0] exp_rnd_d;
    logic [31:0]             result_d;
    logic                    overflow_d;
    logic                    underflow_d;
    logic                    inexact_d;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign inexact   = inexact_q;

    // Leading zeros of the significand counted down from the hidden-bit position.
    always_comb begin
        lz_d = LZ_W'(27);
        for (int i = 0; i < 27; i++) begin
            if (sig_q[i]) begin
                lz_d = LZ_W'(26 - i);
            end
        end
    end

    // One left-normalize step, bounded by the step size, the leading zeros and exp==1.
    always_comb begin
        shamt_d = LZ_W'(SHIFT_STEP);
        if (lz_d < shamt_d) begin
            shamt_d = lz_d;
        end
        if ((exp_q - 10'sd1) < $signed(EXP_W'(shamt_d))) begin
            shamt_d = LZ_W'(exp_q - 10'sd1);
        end
        sig_shl_d = sig_q << shamt_d;
        exp_shl_d = exp_q - $signed(EXP_W'(shamt_d));
        sig_rsh_d = {1'b0, sig_q[27:2], sig_q[1] | sig_q[0]};
    end

    // Round to nearest-even, then classify as overflow, tiny or normal.
    always_comb begin
        inx_raw_d  = |sig_q[2:0];
        round_up_d = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
        m_sum_d    = {1'b0, sig_q[26:3]} + (MAN_W+1)'(round_up_d);
        if (m_sum_d[MAN_W]) begin
            mant_d    = m_sum_d[MAN_W:1];
            exp_rnd_d = exp_q + 10'sd1;
        end else begin
            mant_d    = m_sum_d[MAN_W-1:0];
            exp_rnd_d = exp_q;
        end

        result_d    = {sign_q, (mant_d[23] ? exp_rnd_d[7:0] : 8'h00), mant_d[22:0]};
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        inexact_d   = inx_raw_d;

        if (exp_rnd_d >= 10'sd255) begin
            result_d   = {sign_q, 8'hFF, 23'b0};
            overflow_d = 1'b1;
            inexact_d  = 1'b1;
`ifdef SUBNORMAL_EN
        end else if (!mant_d[23]) begin
            // Subnormal survives; underflow only when precision was actually lost.
            underflow_d = inx_raw_d;
`else
        end else if (!sig_q[26]) begin
            // Normalization ran out of exponent: flush to signed zero.
            result_d    = {sign_q, 31'b0};
            underflow_d = 1'b1;
            inexact_d   = 1'b1;
`endif
        end
    end

    // Control FSM with datapath and registered output updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            sig_q       <= '0;
            exp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sign_q     <= sign_in;
                        sig_q      <= sig_in;
                        exp_q      <= (exp_in == 8'd0) ? 10'sd1 : $signed({2'b00, exp_in});
                        in_ready_q <= 1'b0;
                        state_q    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (sig_q == '0) begin
                        result_q    <= {sign_q, 31'b0};
                        overflow_q  <= 1'b0;
                        underflow_q <= 1'b0;
                        inexact_q   <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (sig_q[27]) begin
                        sig_q   <= sig_rsh_d;
                        exp_q   <= exp_q + 10'sd1;
                        state_q <= S_ROUND;
                    end else if (sig_q[26] || (exp_q <= 10'sd1)) begin
                        state_q <= S_ROUND;
                    end else begin
                        sig_q <= sig_shl_d;
                        exp_q <= exp_shl_d;
                        if (sig_shl_d[26] || (exp_shl_d <= 10'sd1)) begin
                            state_q <= S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    result_q    <= result_d;
                    overflow_q  <= overflow_d;
                    underflow_q <= underflow_d;
                    inexact_q   <= inexact_d;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_round.sv
// Self-checking bench for normalize_round (default flush-to-zero build).
module tb_normalize_round;

    localparam int STEP = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [27:0] sig_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int n_vec;
    int n_err;

    normalize_round #(.SHIFT_STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .sig_in    (sig_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact value arithmetic on the significand, RNE by remainder comparison.
    function automatic void model(input logic s, input logic [7:0] e_in, input logic [27:0] s_in,
                                  output logic [31:0] res, output logic [2:0] flags,
                                  output int lat);
        int     e;
        longint v;
        longint mant;
        longint rem;
        int     p;
        int     lz;
        int     sh;
        int     k;
        logic   tiny;
        e = (e_in == 8'd0) ? 1 : int'(e_in);
        v = longint'(s_in);
        if (v == 0) begin
            res = {s, 31'b0};
            flags = 3'b000;
            lat = 2;
            return;
        end
        if (v >= (longint'(1) << 27)) begin
            v = (v >> 1) | (v & 1);
            e = e + 1;
            k = 1;
        end else begin
            p = 0;
            for (int i = 0; i < 27; i++) if (((v >> i) & 1) != 0) p = i;
            lz = 26 - p;
            sh = (lz < e - 1) ? lz : e - 1;
            v = v << sh;
            e = e - sh;
            k = (sh + STEP - 1) / STEP;
            if (k == 0) k = 1;
        end
        lat = k + 2;
        tiny = (v < (longint'(1) << 26));
        mant = v >> 3;
        rem = v & 7;
        if (rem > 4 || (rem == 4 && (mant % 2) == 1)) mant = mant + 1;
        if (mant == (longint'(1) << 24)) begin
            mant = mant >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            res = {s, 8'hFF, 23'b0};
            flags = 3'b101;
        end else if (tiny) begin
            res = {s, 31'b0};
            flags = 3'b011;
        end else begin
            res = {s, 8'(e), 23'(mant)};
            flags = {2'b00, rem != 0};
        end
    endfunction

    // Issue one operation, check latency, result, flags and the output handshake.
    task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                          input logic [27:0] sg, input int stall);
        logic [31:0] er;
        logic [2:0]  ef;
        int          el;
        int          cyc;
        model(s, e, sg, er, ef, el);
        chk({tag, " idle_ready"}, 64'(in_ready), 64'(1));
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        sign_in   = s;
        exp_in    = e;
        sig_in    = sg;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        chk({tag, " busy_ready"}, 64'(in_ready), 64'(0));
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(el));
        chk({tag, " result"}, 64'(result), 64'(er));
        chk({tag, " flags_ovf_unf_inx"}, 64'({overflow, underflow, inexact}), 64'(ef));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, " stall_hold"}, {30'b0, out_valid, in_ready, result}, {30'b0, 1'b1, 1'b0, er});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " post_handshake"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    logic [7:0]  bexp [5];
    logic [27:0] rsig;
    logic [7:0]  rexp;
    int          cyc0;

    initial begin
        n_vec = 0;
        n_err = 0;
        bexp[0] = 8'd0; bexp[1] = 8'd1; bexp[2] = 8'd2; bexp[3] = 8'd254; bexp[4] = 8'd255;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sign_in = 1'b0; exp_in = '0; sig_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {25'b0, in_ready, out_valid, overflow, underflow, inexact, 2'b0, result},
            {25'b0, 1'b1, 1'b0, 3'b000, 2'b0, 32'h0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("T1_one",       1'b0, 8'd127, 28'h4000000, 0);
        run_op("T2_carry",     1'b0, 8'd127, 28'h8000008, 0);
        run_op("T3_lz20",      1'b0, 8'd127, 28'h0000040, 0);
        run_op("T4_overflow",  1'b0, 8'd254, 28'h7FFFFFC, 0);
        run_op("T5_ftz",       1'b0, 8'd2,   28'h0100000, 0);
        run_op("zero_sig",     1'b1, 8'd90,  28'h0000000, 0);
        run_op("exp0_as_1",    1'b0, 8'd0,   28'h4000004, 0);
        run_op("tie_odd_up",   1'b1, 8'd100, 28'h400000C, 0);
        run_op("T6_stall",     1'b0, 8'd127, 28'h4000000, 10);

        // Reset in the middle of normalization drops the operation.
        in_valid = 1'b1; sign_in = 1'b0; exp_in = 8'd127; sig_in = 28'h0000040;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("T6_midreset", 64'({out_valid, in_ready}), 64'(2'b01));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc0 = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) cyc0++;
        end
        chk("T6_no_stale_valid", 64'(cyc0), 64'(0));
        run_op("T6_after_reset", 1'b0, 8'd127, 28'h4000000, 0);

        // Randomized operands with a bias toward exponent and leading-zero boundaries.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: rsig = 28'($urandom);
                1: rsig = 28'($urandom & 32'h07FFFFFF) >> $urandom_range(0, 27);
                2: rsig = {2'b01, 26'($urandom)};
                default: rsig = {1'b1, 27'($urandom)};
            endcase
            if ($urandom_range(0, 2) == 0) rexp = bexp[$urandom_range(0, 4)];
            else rexp = 8'($urandom_range(0, 255));
            run_op("rand", 1'($urandom), rexp, rsig, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
